// File: rtl/timer_device_pkg.sv
// Shared register map, CTRL field positions and FSM encoding for the countdown timer.
package timer_device_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_BITS    = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator: one-cycle tick every PRESCALE cycles while clear is low.
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and masked level irq.
// IDLE waits for EN, LOAD copies PRESET, CNT counts ticks down, INT raises the flag.
module timer_device
  import timer_device_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             irq
);

  logic [CTRL_BITS-1:0] ctrl;
  logic [WIDTH-1:0]     preset;
  logic [WIDTH-1:0]     count;
  logic                 irq_flag;
  state_t               state;

  logic wr_ctrl;
  logic wr_preset;
  logic en_next;
  logic one_shot;
  logic presc_clear;
  logic tick;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);
  // EN as it will be after this edge, so a CTRL write starts LOAD on the same edge
  assign en_next   = wr_ctrl ? wd[CTRL_EN] : ctrl[CTRL_EN];
  assign one_shot  = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] != MODE_RELOAD);
  assign presc_clear = (state != ST_CNT);

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      if (wr_ctrl) ctrl <= wd[CTRL_BITS-1:0];
      if (wr_preset) preset <= wd;
      if (wr_ctrl || wr_preset) irq_flag <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (en_next) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!en_next) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else begin
              count <= '0;
              state <= ST_INT;
            end
          end
        end
        ST_INT: begin
          // the set overrides a same-cycle clearing write so no expiry is lost
          irq_flag <= 1'b1;
          if (one_shot) begin
            if (!wr_ctrl) ctrl[CTRL_EN] <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign irq = irq_flag & ctrl[CTRL_IM];

  always_comb begin
    rd = '0;
    case (addr)
      ADDR_CTRL:   rd = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl};
      ADDR_PRESET: rd = preset;
      ADDR_COUNT:  rd = count;
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_timer_device;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic        we4;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] rd4;
  logic        irq;
  logic        irq4;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_PRE  = 2'd1;
  localparam logic [1:0] A_CNT  = 2'd2;
  localparam logic [1:0] A_NONE = 2'd3;

  timer_device #(.WIDTH(32), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd), .rd(rd), .irq(irq)
  );

  timer_device #(.WIDTH(32), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .we(we4), .wd(wd), .rd(rd4), .irq(irq4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wd = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic wr4(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wd = d; we4 = 1'b1;
    @(posedge clk);
    #1;
    we4 = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd, exp);
  endtask

  task automatic rdchk4(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd4, exp);
  endtask

  logic [31:0] pre4_cnt [1:10];
  logic        pre4_irq [1:10];

  initial begin
    reset = 1'b0; addr = A_CTRL; we = 1'b0; we4 = 1'b0; wd = '0;
    pre4_cnt = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 0};
    pre4_irq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    #12;
    rdchk("rst_ctrl", A_CTRL, 32'd0);
    rdchk("rst_preset", A_PRE, 32'd0);
    rdchk("rst_count", A_CNT, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // one-shot, PRESET=5
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    for (int i = 1; i <= 5; i++) begin
      step();
      rdchk($sformatf("os_count_e%0d", i), A_CNT, 32'(6 - i));
      chk("os_irq_low", {31'd0, irq}, 32'd0);
    end
    step();
    rdchk("os_count_zero", A_CNT, 32'd0);
    chk("os_irq_int", {31'd0, irq}, 32'd0);
    step();
    chk("os_irq_high", {31'd0, irq}, 32'd1);
    rdchk("os_ctrl_en_cleared", A_CTRL, 32'h8);
    step();
    chk("os_irq_level", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 32'h8);
    chk("os_irq_cleared", {31'd0, irq}, 32'd0);

    // auto-reload, PRESET=3
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    step();
    rdchk("ar_count_load", A_CNT, 32'd3);
    step(); step(); step();
    rdchk("ar_count_zero", A_CNT, 32'd0);
    chk("ar_irq_int", {31'd0, irq}, 32'd0);
    step();
    chk("ar_irq_first", {31'd0, irq}, 32'd1);
    step();
    rdchk("ar_count_reload", A_CNT, 32'd3);
    chk("ar_irq_held", {31'd0, irq}, 32'd1);
    wr(A_PRE, 32'd2);
    rdchk("ar_preset_no_effect", A_CNT, 32'd2);
    chk("ar_irq_clr_preset", {31'd0, irq}, 32'd0);
    step();
    chk("ar_irq_e8", {31'd0, irq}, 32'd0);
    step();
    chk("ar_irq_e9", {31'd0, irq}, 32'd0);
    step();
    chk("ar_irq_second", {31'd0, irq}, 32'd1);
    step();
    rdchk("ar_count_newpreset", A_CNT, 32'd2);
    wr(A_CTRL, 32'h0);
    rdchk("ar_stop_count", A_CNT, 32'd2);
    step();
    rdchk("ar_stop_hold", A_CNT, 32'd2);

    // masked expiry, PRESET=2, IM=0
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h1);
    step(); step(); step(); step();
    rdchk("mask_count", A_CNT, 32'd0);
    rdchk("mask_ctrl", A_CTRL, 32'h0);
    chk("mask_irq", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'h8);
    chk("mask_im_clears", {31'd0, irq}, 32'd0);

    // disable mid-count freezes, re-enable restarts from PRESET
    wr(A_PRE, 32'd6);
    wr(A_CTRL, 32'h9);
    step(); step(); step();
    rdchk("frz_count_e3", A_CNT, 32'd4);
    wr(A_CTRL, 32'h8);
    rdchk("frz_count", A_CNT, 32'd4);
    step(); step();
    rdchk("frz_hold", A_CNT, 32'd4);
    wr(A_CTRL, 32'h9);
    step();
    rdchk("restart_load", A_CNT, 32'd6);
    wr(A_CTRL, 32'h0);
    rdchk("restart_stop", A_CNT, 32'd6);

    // bus corners
    wr(A_CNT, 32'hFFFF);
    rdchk("count_write_ignored", A_CNT, 32'd6);
    wr(A_NONE, 32'h1234);
    rdchk("unmapped_read", A_NONE, 32'd0);
    rdchk("unmapped_ctrl", A_CTRL, 32'd0);
    rdchk("unmapped_preset", A_PRE, 32'd6);

    // CTRL write on the INT cycle: flag set wins, written EN wins
    wr(A_PRE, 32'd1);
    wr(A_CTRL, 32'h9);
    step();
    rdchk("coll_count_load", A_CNT, 32'd1);
    step();
    rdchk("coll_count_zero", A_CNT, 32'd0);
    wr(A_CTRL, 32'h9);
    chk("coll_irq_kept", {31'd0, irq}, 32'd1);
    rdchk("coll_ctrl_cpu_wins", A_CTRL, 32'h9);
    wr(A_CTRL, 32'h8);

    // PRESET=0 expires after one tick
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h9);
    step();
    step();
    chk("p0_irq_int", {31'd0, irq}, 32'd0);
    step();
    chk("p0_irq_high", {31'd0, irq}, 32'd1);
    rdchk("p0_count", A_CNT, 32'd0);
    wr(A_CTRL, 32'h0);

    // PRESCALE=4 instance, PRESET=2
    wr4(A_PRE, 32'd2);
    wr4(A_CTRL, 32'h9);
    for (int i = 1; i <= 10; i++) begin
      step();
      rdchk4($sformatf("ps_count_e%0d", i), A_CNT, pre4_cnt[i]);
      chk($sformatf("ps_irq_e%0d", i), {31'd0, irq4}, {31'd0, pre4_irq[i]});
    end

    // asynchronous reset mid-count
    wr(A_PRE, 32'd9);
    wr(A_CTRL, 32'h9);
    step(); step(); step();
    rdchk("mid_count_before", A_CNT, 32'd7);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", rd, 32'd0);
    rdchk("mid_rst_ctrl", A_CTRL, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(); step();
    rdchk("mid_rst_idle", A_CNT, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Memory-mapped countdown timer on the data-memory bus, written and read by the MEM stage (load/store to the timer window) and feeding an interrupt request to the CP0 exception logic.
- Holds three word registers: CTRL, PRESET and COUNT.
- Counts down from PRESET and raises `irq` on expiry.
- Supports one-shot and auto-reload modes, with an optional tick prescaler.

Parameters:
- WIDTH, 32, register and bus data width.
- PRESCALE, 1, clock cycles per COUNT decrement; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- addr  input  2  register select (bus address bits [3:2]): 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- we  input  1  write strobe, qualified by the bridge chip-select.
- wd  input  WIDTH  write data.
- rd  output  WIDTH  read data, combinational from `addr`.
- irq  output  1  interrupt request to CP0; level signal.

Behaviour:
- CTRL fields:
  - [0] EN: enable.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as one-shot.
  - [3] IM: interrupt mask, 1 = allow `irq`.
  - Bits [WIDTH-1:4] are not stored and read as 0.
- Reset (asynchronous, `reset` = 0): CTRL=0, PRESET=0, COUNT=0, prescaler=0, state=IDLE, irq_flag=0. `irq` is therefore 0 and `rd` reflects the zeroed registers.
- Writes take effect on the clock edge where `we`=1.
  - Write to COUNT is ignored.
  - Write to addr 3 is ignored; a read of addr 3 returns 0.
- Any write to CTRL or PRESET clears irq_flag.
- `irq` = irq_flag & IM. It is registered, so there is no combinational path from `wd`.
- FSM states:
  - IDLE:
    - If EN=1, go to LOAD next cycle.
    - COUNT holds its value.
  - LOAD:
    - COUNT <= PRESET, prescaler <= 0; go to CNT.
    - One cycle.
  - CNT:
    - If EN=0, go to IDLE and freeze COUNT.
    - Otherwise increment the prescaler each cycle. When prescaler == PRESCALE-1, clear the prescaler and process one tick:
      - if COUNT > 1: COUNT <= COUNT-1;
      - if COUNT is 1 or 0: COUNT <= 0 and go to INT.
    - A PRESET of 0 behaves as a PRESET of 1.
  - INT (one cycle):
    - irq_flag <= 1.
    - MODE one-shot: EN <= 0, go to IDLE.
    - MODE auto-reload: go to LOAD.
- Latency, PRESCALE=1, PRESET=N≥1: EN written at edge 0 → LOAD at edge 1 → COUNT=N after edge 1 → COUNT=1 after edge N → INT entered at edge N+1 → `irq` high after edge N+2.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as the INT-state EN clear: the CPU write wins.
  - A CPU write to CTRL/PRESET in the same cycle as INT setting irq_flag: the set wins, so no interrupt is lost.
- A PRESET write during CNT affects only the next LOAD.
- An EN 1→0→1 sequence restarts from LOAD; the count does not resume.
- `reset` asserted mid-count returns everything to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package / macro header holds:
  - register offsets: CTRL=0, PRESET=1, COUNT=2;
  - CTRL bit positions: EN=0, MODE=2:1, IM=3;
  - MODE encodings;
  - FSM state encoding: IDLE, LOAD, CNT, INT (2 bits).
- One sub-module is natural: `timer_prescaler`, a tick generator that takes clk, reset and clear and emits a 1-cycle tick every PRESCALE cycles.

Test Plan:
- Reset check: assert `reset`=0 mid-CNT with COUNT=7 → COUNT, CTRL, `irq` read 0 immediately; state returns to IDLE.
- One-shot: PRESET=5, then CTRL=0x9 (EN, IM, one-shot) → COUNT reads 5,4,3,2,1,0; `irq`=1 two edges after COUNT=1; CTRL reads 0x8 afterwards; a CTRL write clears `irq`.
- Auto-reload: PRESET=3, CTRL=0xB → irq_flag set every 5 cycles (LOAD + 3 ticks + INT); COUNT reloads to 3; `irq` remains 1 until CTRL/PRESET is written.
- Mask and disable: CTRL=0x1 with PRESET=2 → expiry occurs with `irq`=0; then write IM=1 → `irq` stays 0 because the flag was cleared by that write. Separately, EN=0 mid-count freezes COUNT at 4.
- Prescaler: PRESCALE=4, PRESET=2, CTRL=0x9 → COUNT decrements every 4 cycles; `irq` rises at cycle 1+8+1+1.
- Bus corner cases:
  - a write to COUNT (0xFFFF) leaves COUNT unchanged;
  - addr 3 reads 0;
  - a CTRL write coinciding with the INT state keeps irq_flag=1;
  - PRESET=0 expires after 1 tick.
